// File: rtl/div_unit.sv
// Multi-cycle integer divider for DIV/DIVU/REM/REMU: one restoring step per
// cycle on operand magnitudes, sign correction applied on the last step.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;

    // Request decode: op[0]==0 selects the signed flavours.
    logic             signed_in;
    logic             a_neg_in, b_neg_in;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             overflow_in;

    assign signed_in   = ~op[0];
    assign a_neg_in    = signed_in & A[WIDTH-1];
    assign b_neg_in    = signed_in & B[WIDTH-1];
    assign a_mag       = a_neg_in ? ('0 - A) : A;
    assign b_mag       = b_neg_in ? ('0 - B) : B;
    assign overflow_in = signed_in && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);

    // quo_q shifts dividend bits out of its MSB while quotient bits enter at the LSB.
    logic [WIDTH:0]   trial, diff;
    logic             no_borrow;
    logic [WIDTH-1:0] acc_step, quo_step;
    logic [WIDTH-1:0] q_fix, r_fix;

    assign trial     = {acc_q, quo_q[WIDTH-1]};
    assign diff      = trial - {1'b0, dvs_q};
    assign no_borrow = ~diff[WIDTH];
    assign acc_step  = no_borrow ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_step  = {quo_q[WIDTH-2:0], no_borrow};
    assign q_fix     = (~op_q[0] & (a_neg_q ^ b_neg_q)) ? ('0 - quo_step) : quo_step;
    assign r_fix     = a_neg_q ? ('0 - acc_step) : acc_step;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    acc_d   = '0;
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    cnt_d   = '0;
                    a_neg_d = a_neg_in;
                    b_neg_d = b_neg_in;
                    if (B == '0) begin
                        result_d = op[1] ? A : '1;
                        state_d  = DONE;
                    end else if (overflow_in) begin
                        result_d = op[1] ? '0 : A;
                        state_d  = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = acc_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    result_d = op_q[1] ? r_fix : q_fix;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Result    = result_q;

endmodule
